// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle controller: state encoding,
// instruction opcodes, R-type funct codes and ALU operation codes.
package mc_pkg;

    // Instruction opcodes (instr[31:26])
    localparam logic [5:0] OP_LW_C    = 6'b010101;
    localparam logic [5:0] OP_SW_C    = 6'b010100;
    localparam logic [5:0] OP_RTYPE_C = 6'b000000;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC    = 4'd7,
        S_ALUWB   = 4'd8,
        S_ILLEGAL = 4'd9
    } state_t;

    // Final state of an instruction: done pulses here and a new start is accepted.
    function automatic logic is_done_state(input state_t s);
        return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_ALUWB) || (s == S_ILLEGAL);
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational R-type funct decoder: maps funct to an ALU operation code and
// flags whether the funct is one the datapath supports.
module alu_decoder
    import mc_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [2:0] alu_control_o,
    output logic       funct_ok_o
);

    // Table lookup; unsupported functs report funct_ok_o = 0 and a neutral code.
    always_comb begin
        alu_control_o = ALU_AND;
        funct_ok_o    = 1'b1;
        case (funct_i)
            FN_ADD:  alu_control_o = ALU_ADD;
            FN_SUB:  alu_control_o = ALU_SUB;
            FN_AND:  alu_control_o = ALU_AND;
            FN_OR:   alu_control_o = ALU_OR;
            FN_SLT:  alu_control_o = ALU_SLT;
            default: funct_ok_o    = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control FSM for the shared register file / ALU / data memory
// datapath. Executes one lw, sw or R-type instruction per start/done
// transaction and counts retired (legal) instructions.
//
// Handshake: start is a request qualified only in IDLE or in a done cycle;
// when it is accepted, instr is captured into instr_q on that same edge and
// the next instruction begins. start in any other state is ignored. done is
// a single-cycle pulse in the instruction's final state; illegal accompanies
// done when the opcode/funct is unsupported. A start held high through a
// done cycle chains the next instruction with no IDLE bubble.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter logic [5:0] OP_LW    = OP_LW_C,
    parameter logic [5:0] OP_SW    = OP_SW_C,
    parameter logic [5:0] OP_RTYPE = OP_RTYPE_C,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      instr,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [31:0]      instr_q,
    output logic             ir_write,
    output logic             reg_write,
    output logic             mem_write,
    output logic             alu_src,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic [2:0]       alu_control,
    output logic [CNT_W-1:0] retired_count,
    output state_t           dbg_state_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       opcode;
    logic [2:0]       dec_alu;
    logic             dec_ok;
    logic             accept;

    assign opcode        = ir_q[31:26];
    assign instr_q       = ir_q;
    assign retired_count = cnt_q;
    assign dbg_state_o   = state_q;
    assign busy          = (state_q != S_IDLE);
    assign accept        = start && ((state_q == S_IDLE) || is_done_state(state_q));

    alu_decoder u_alu_decoder (
        .funct_i       (ir_q[5:0]),
        .alu_control_o (dec_alu),
        .funct_ok_o    (dec_ok)
    );

    // State, instruction register and retired counter; reset aborts any instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

    // IR capture on accept; saturating count of legal completions.
    always_comb begin
        ir_d  = ir_q;
        cnt_d = cnt_q;
        if (accept) begin
            ir_d = instr;
        end
        if (done && !illegal && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Next-state sequencing: decode on the latched opcode, chain on start in done states.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if ((opcode == OP_LW) || (opcode == OP_SW)) begin
                    state_d = S_MEMADR;
                end else if ((opcode == OP_RTYPE) && dec_ok) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_ILLEGAL;
                end
            end
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_ALUWB;
            S_MEMWB, S_MEMWR, S_ALUWB, S_ILLEGAL: begin
                state_d = start ? S_FETCH : S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // Moore control outputs decoded from the registered state.
    always_comb begin
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        mem_write   = 1'b0;
        alu_src     = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_control = ALU_AND;
        done        = 1'b0;
        illegal     = 1'b0;
        case (state_q)
            S_FETCH: ir_write = 1'b1;
            S_MEMADR, S_MEMRD: begin
                alu_src     = 1'b1;
                alu_control = ALU_ADD;
            end
            S_MEMWB: begin
                // Address path held steady while the loaded word is written back.
                alu_src     = 1'b1;
                alu_control = ALU_ADD;
                reg_write   = 1'b1;
                mem_to_reg  = 1'b1;
                done        = 1'b1;
            end
            S_MEMWR: begin
                alu_src     = 1'b1;
                alu_control = ALU_ADD;
                mem_write   = 1'b1;
                done        = 1'b1;
            end
            S_EXEC: alu_control = dec_alu;
            S_ALUWB: begin
                alu_control = dec_alu;
                reg_dst     = 1'b1;
                reg_write   = 1'b1;
                done        = 1'b1;
            end
            S_ILLEGAL: begin
                done    = 1'b1;
                illegal = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller. The reference
// model classifies each instruction (lw / sw / R-type / illegal) and derives
// the expected per-cycle outputs from its position within the instruction.
module tb_multicycle_controller;
  import mc_pkg::*;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum int {K_LW, K_SW, K_R, K_ILL} kind_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic [31:0]      instr;
  logic             busy, done, illegal;
  logic [31:0]      instr_q;
  logic             ir_write, reg_write, mem_write;
  logic             alu_src, reg_dst, mem_to_reg;
  logic [2:0]       alu_control;
  logic [CNT_W-1:0] retired_count;
  state_t           dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [CNT_W-1:0] exp_cnt;
  logic [31:0] exp_q[$];

  logic [5:0] fn_tab [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [2:0] alu_tab[5] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111};

  multicycle_controller #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .instr         (instr),
    .busy          (busy),
    .done          (done),
    .illegal       (illegal),
    .instr_q       (instr_q),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .mem_write     (mem_write),
    .alu_src       (alu_src),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .alu_control   (alu_control),
    .retired_count (retired_count),
    .dbg_state_o   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model
  function automatic int fn_index(input logic [5:0] fn);
    for (int i = 0; i < 5; i++) if (fn_tab[i] == fn) return i;
    return -1;
  endfunction

  function automatic kind_t classify(input logic [31:0] ins);
    if (ins[31:26] == 6'b010101) return K_LW;
    if (ins[31:26] == 6'b010100) return K_SW;
    if (ins[31:26] == 6'b000000 && fn_index(ins[5:0]) >= 0) return K_R;
    return K_ILL;
  endfunction

  function automatic int latency(input kind_t k);
    case (k)
      K_LW:    return 5;
      K_SW:    return 4;
      K_R:     return 4;
      default: return 3;
    endcase
  endfunction

  function automatic state_t exp_state(input kind_t k, input int c);
    state_t lw_seq[5]  = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB};
    state_t sw_seq[4]  = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWR};
    state_t r_seq[4]   = '{S_FETCH, S_DECODE, S_EXEC, S_ALUWB};
    state_t ill_seq[3] = '{S_FETCH, S_DECODE, S_ILLEGAL};
    case (k)
      K_LW:    return lw_seq[c-1];
      K_SW:    return sw_seq[c-1];
      K_R:     return r_seq[c-1];
      default: return ill_seq[c-1];
    endcase
  endfunction

  // Compare every output against the model for cycle c (1 = FETCH) of ins.
  task automatic check_cycle(input logic [31:0] ins, input int c);
    kind_t k;
    int    lat;
    bit    last, memph;
    logic [2:0] ealu;
    k     = classify(ins);
    lat   = latency(k);
    last  = (c == lat);
    memph = ((k == K_LW) || (k == K_SW)) && (c >= 3);
    ealu  = 3'b000;
    if (memph) ealu = 3'b010;
    else if (k == K_R && c >= 3) ealu = alu_tab[fn_index(ins[5:0])];
    check_eq("state",       dbg_state,     exp_state(k, c));
    check_eq("busy",        busy,          1);
    check_eq("ir_write",    ir_write,      c == 1);
    check_eq("done",        done,          last);
    check_eq("illegal",     illegal,       last && (k == K_ILL));
    check_eq("reg_write",   reg_write,     last && (k == K_LW || k == K_R));
    check_eq("mem_write",   mem_write,     last && (k == K_SW));
    check_eq("alu_src",     alu_src,       memph);
    check_eq("reg_dst",     reg_dst,       last && (k == K_R));
    check_eq("mem_to_reg",  mem_to_reg,    last && (k == K_LW));
    check_eq("alu_control", alu_control,   ealu);
    check_eq("instr_q",     instr_q,       ins);
    check_eq("retired",     retired_count, exp_cnt);
  endtask

  task automatic check_idle(input string tag, input logic [31:0] held);
    check_eq({tag, "_state"}, dbg_state, S_IDLE);
    check_eq({tag, "_ctrl"},
             {busy, done, illegal, ir_write, reg_write, mem_write, alu_src, reg_dst, mem_to_reg, alu_control},
             0);
    check_eq({tag, "_instr_q"}, instr_q, held);
    check_eq({tag, "_retired"}, retired_count, exp_cnt);
  endtask

  // driver: at entry start/instr for ins are already driven at a negedge.
  // Non-final cycles drive random start pulses and garbage instr, which must be ignored.
  task automatic run_instr(input logic [31:0] ins, input bit chain, input logic [31:0] nxt);
    int lat;
    lat = latency(classify(ins));
    @(posedge clk);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      check_cycle(ins, c);
      if (c < lat) begin
        start = 1'($urandom_range(0, 1));
        instr = $urandom;
        @(posedge clk);
      end else if (chain) begin
        start = 1'b1;
        instr = nxt;
      end else begin
        start = 1'b0;
        instr = $urandom;
      end
    end
    if (classify(ins) != K_ILL && exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic issue_single(input logic [31:0] ins);
    start = 1'b1;
    instr = ins;
    run_instr(ins, 1'b0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check_idle("idle", ins);
    repeat ($urandom_range(0, 2)) begin
      instr = $urandom;
      @(negedge clk);
      check_eq("idle_hold", instr_q, ins);
    end
  endtask

  // Run exp_q as a chain of instructions; chain flags random unless forced.
  task automatic issue_queue(input bit force_chain);
    logic [31:0] cur, nxt;
    bit ch;
    cur   = exp_q.pop_front();
    start = 1'b1;
    instr = cur;
    while (1) begin
      ch  = (exp_q.size() > 0) && (force_chain || ($urandom_range(0, 1) == 1));
      nxt = (exp_q.size() > 0) ? exp_q[0] : 32'h0;
      run_instr(cur, ch, nxt);
      if (!ch) begin
        @(posedge clk);
        @(negedge clk);
        check_idle("q_idle", cur);
        if (exp_q.size() == 0) break;
        cur   = exp_q.pop_front();
        start = 1'b1;
        instr = cur;
      end else begin
        cur = exp_q.pop_front();
      end
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] t;
    t = $urandom;
    case ($urandom_range(0, 3))
      0: return {6'b010101, t[25:0]};
      1: return {6'b010100, t[25:0]};
      2: begin
        if ($urandom_range(0, 3) != 0) return {6'b000000, t[25:6], fn_tab[$urandom_range(0, 4)]};
        return {6'b000000, t[25:0]};
      end
      default: return t;
    endcase
  endfunction

  // main sequence
  initial begin
    rst     = 1'b0;
    start   = 1'b0;
    instr   = 32'h0;
    exp_cnt = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset", 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check_idle("post_reset", 32'h0);

    // directed: lw, sw, sub, slt, illegal opcode, illegal funct
    issue_single(32'b010101_00000_00001_0000000000000101);
    check_eq("lw_retired", retired_count, 1);
    issue_single(32'b010100_00000_01001_0000000000000010);
    issue_single({6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100010});
    issue_single({6'b000000, 5'd4, 5'd5, 5'd6, 5'd0, 6'b101010});
    issue_single({6'b111111, 26'h1234567});
    issue_single({6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b000111});
    check_eq("after_illegal_retired", retired_count, 4);

    // three back-to-back sw with start held
    for (int i = 0; i < 3; i++) exp_q.push_back({6'b010100, 5'd0, 5'(i + 9), 16'(i)});
    issue_queue(1'b1);

    // randomized mix with random chaining
    for (int i = 0; i < 40; i++) exp_q.push_back(rand_instr());
    issue_queue(1'b0);

    // drive the counter to saturation, then one more lw must leave it there
    for (int i = 0; i < 20 && exp_cnt != CNT_MAX; i++) issue_single({6'b010101, 26'(i)});
    check_eq("sat_before", retired_count, CNT_MAX);
    issue_single({6'b010101, 26'h3});
    check_eq("sat_after", retired_count, CNT_MAX);

    // reset asserted while a lw sits in MEMRD
    start = 1'b1;
    instr = {6'b010101, 26'h0ABCD};
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    check_eq("pre_rst_state", dbg_state, S_MEMRD);
    #2 rst = 1'b0;
    exp_cnt = '0;
    #1;
    check_idle("async_rst", 32'h0);
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_no_reg_write", reg_write, 0);
      check_eq("rst_no_done", done, 0);
    end
    rst = 1'b1;
    @(negedge clk);
    check_idle("rst_release", 32'h0);
    issue_single(32'b010101_00000_00001_0000000000000101);
    check_eq("final_retired", retired_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Multicycle control FSM that sequences the shared register file / ALU / data memory datapath, one instruction per start/done transaction. Decodes lw, sw and R-type instructions, drives ir_write, reg_write, mem_write and the ALUSrc, RegDst and MemtoReg mux selects plus ALUControl. Keeps a retired-instruction count for the seven-segment probe path. Replaces the hard-wired select constants and the bit-26 write-enable decode at top level.

Parameters:
OP_LW, 6'b010101, opcode of load word
OP_SW, 6'b010100, opcode of store word
OP_RTYPE, 6'b000000, opcode of R-type ALU ops
CNT_W, 16, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
start  input  1  request to execute instr; sampled in IDLE or in a done cycle
instr  input  32  instruction word, sampled only when start is accepted
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse in the final state of each instruction
illegal  output  1  high together with done when opcode/funct is unsupported
instr_q  output  32  latched instruction (IR), drives datapath field slices
ir_write  output  1  high in FETCH only
reg_write  output  1  register file WE3
mem_write  output  1  data memory WE
alu_src  output  1  1 = SignImm, 0 = RD2
reg_dst  output  1  1 = rd [15:11], 0 = rt [20:16]
mem_to_reg  output  1  1 = ReadData, 0 = ALUResult
alu_control  output  3  ALU operation code
retired_count  output  CNT_W  instructions completed without illegal

Behaviour:
- Reset (rst low, async): state = IDLE; instr_q = 0; retired_count = 0; all control outputs 0. Reset mid-instruction aborts it with no write strobe and no done.
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ILLEGAL. Moore outputs decoded from the registered state.
- IDLE: start=1 -> FETCH, capture instr into instr_q on the same edge.
- FETCH: ir_write=1 -> DECODE.
- DECODE: opcode = instr_q[31:26]. OP_LW or OP_SW -> MEMADR. OP_RTYPE with a supported funct -> EXEC. Anything else -> ILLEGAL.
- MEMADR: alu_src=1, alu_control=010 (add). Next state MEMRD for lw, MEMWR for sw.
- MEMRD: alu_src=1, alu_control=010 -> MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, done=1.
- MEMWR: mem_write=1, alu_src=1, alu_control=010, done=1.
- EXEC: alu_src=0, alu_control from funct -> ALUWB.
- ALUWB: alu_src=0, reg_dst=1, mem_to_reg=0, reg_write=1, alu_control held, done=1.
- ILLEGAL: done=1, illegal=1. No write strobes.
- Funct decode: 100000 -> 010 add; 100010 -> 110 sub; 100100 -> 000 and; 100101 -> 001 or; 101010 -> 111 slt. Any other funct is illegal.
- Done states: start=1 -> FETCH, capturing the new instr (back-to-back, no IDLE bubble). Otherwise -> IDLE.
- start in any other state is ignored and has no effect on instr_q.
- Latency from the start-accept edge to done: lw 5 cycles, sw 4, R-type 4, illegal 3.
- reg_write and mem_write are never high in the same cycle. Each is high for exactly one cycle per instruction.
- retired_count increments in done cycles where illegal=0. It saturates at all-ones and does not wrap.

Decomposition:
- Package mc_pkg: state_t enum; opcode constants; funct constants; ALU control codes (ALU_ADD=010, ALU_SUB=110, ALU_AND=000, ALU_OR=001, ALU_SLT=111).
- Sub-module alu_decoder: combinational, funct[5:0] -> alu_control[2:0] plus funct_ok.

Test Plan:
- Reset, then start with lw 32'b010101_00000_00001_0000000000000101 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; done at cycle 5; reg_write, mem_to_reg, alu_src =1 in MEMWB; retired_count = 1.
- sw 32'b010100_00000_01001_0000000000000010 -> mem_write=1 only in the cycle-4 done state; reg_write never high; alu_control = 010.
- R-type funct 100010 (sub), then 101010 (slt) -> alu_control 110 and 111 in EXEC/ALUWB; reg_dst=1; done at cycle 4 each.
- Opcode 6'b111111 and R-type funct 000111 -> done and illegal at cycle 3; no write strobes; retired_count unchanged.
- start held high for 3 back-to-back sw -> new FETCH immediately after each done; 12 cycles total; start pulses during busy ignored and instr_q stable.
- Assert rst low during MEMRD -> outputs 0 immediately, state IDLE, no reg_write; with retired_count preset to all-ones, a further lw leaves it saturated.
